// File: rtl/median_pkg.sv
// Types and helpers shared by the median filter pipeline: pixel/column
// typedefs and the small compare primitives used by the sorting network.
package median_pkg;
  localparam int PIX_W = 24;
  localparam int CH_W  = 8;
  localparam int COL_W = 11;
  localparam int ROW_W = 10;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [CH_W-1:0]  chan_t;

  typedef struct packed {
    pixel_t prev;
    pixel_t cur;
    pixel_t next;
  } column_t;

  // Source of the left/centre/right window columns, picked at launch time
  // depending on edge replication and whether the shift register moved.
  typedef enum logic [1:0] {
    WIN_NORM       = 2'd0,
    WIN_LREP       = 2'd1,
    WIN_FLUSH_SH   = 2'd2,
    WIN_FLUSH_HOLD = 2'd3
  } win_sel_e;

  function automatic chan_t min2(input chan_t a, input chan_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic chan_t max2(input chan_t a, input chan_t b);
    return (a < b) ? b : a;
  endfunction

  function automatic chan_t min3(input chan_t a, input chan_t b, input chan_t c);
    return min2(min2(a, b), c);
  endfunction

  function automatic chan_t max3(input chan_t a, input chan_t b, input chan_t c);
    return max2(max2(a, b), c);
  endfunction

  function automatic chan_t med3(input chan_t a, input chan_t b, input chan_t c);
    return max2(min2(a, b), min2(max2(a, b), c));
  endfunction
endpackage

// File: rtl/median3x3_filter_if.sv
// Pixel stream bundle between the line buffer, the median filter and the packer.
// valid_i qualifies the three line pixels for one cycle and every valid column is
// accepted (no ready); valid_o qualifies data_o, eol_o and eof_o for one cycle.
interface median3x3_filter_if #(
  parameter int DATA_W = 24
);
  logic              valid_i;
  logic [DATA_W-1:0] prev_line_data_i;
  logic [DATA_W-1:0] cur_line_data_i;
  logic [DATA_W-1:0] next_line_data_i;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic              eol_o;
  logic              eof_o;

  modport master (
    output valid_i, prev_line_data_i, cur_line_data_i, next_line_data_i,
    input  valid_o, data_o, eol_o, eof_o
  );

  modport slave (
    input  valid_i, prev_line_data_i, cur_line_data_i, next_line_data_i,
    output valid_o, data_o, eol_o, eof_o
  );
endinterface

// File: rtl/median9_ch.sv
// Three-stage registered median-of-9 for one 8-bit channel: column sort,
// lo/mid/hi reduction, final median of three.
module median9_ch
  import median_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  chan_t [2:0] col_l,
  input  chan_t [2:0] col_c,
  input  chan_t [2:0] col_r,
  output chan_t       med
);
  chan_t [2:0][2:0] win;
  chan_t [2:0]      lo_q, mid_q, hi_q;
  chan_t            a_q, b_q, c_q;

  assign win = {col_r, col_c, col_l};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_q  <= '0;
      mid_q <= '0;
      hi_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      c_q   <= '0;
      med   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        lo_q[i]  <= min3(win[i][0], win[i][1], win[i][2]);
        mid_q[i] <= med3(win[i][0], win[i][1], win[i][2]);
        hi_q[i]  <= max3(win[i][0], win[i][1], win[i][2]);
      end
      a_q <= max3(lo_q[0], lo_q[1], lo_q[2]);
      b_q <= med3(mid_q[0], mid_q[1], mid_q[2]);
      c_q <= min3(hi_q[0], hi_q[1], hi_q[2]);
      med <= med3(a_q, b_q, c_q);
    end
  end
endmodule

// File: rtl/median3x3_filter.sv
// 3x3 per-channel median filter: column shift register, left/right edge
// replication, line flush, output position counters and valid/eol/eof delay.
module median3x3_filter
  import median_pkg::column_t, median_pkg::chan_t, median_pkg::CH_W,
         median_pkg::win_sel_e, median_pkg::WIN_NORM, median_pkg::WIN_LREP,
         median_pkg::WIN_FLUSH_SH, median_pkg::WIN_FLUSH_HOLD;
#(
  parameter int DATA_W = 24,
  parameter int COL_W  = 11,
  parameter int ROW_W  = 10
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [COL_W-1:0]     img_width,
  input  logic [ROW_W-1:0]     img_height,
  median3x3_filter_if.slave    bus
);
  column_t          c_new, c_mid, c_old, col_in;
  column_t          win_l, win_c, win_r;
  logic [COL_W-1:0] in_col, out_col, last_col;
  logic [ROW_W-1:0] out_row, last_row;
  logic             flush_pend, launch, in_last;
  win_sel_e         win_sel;
  logic [3:0]       v_pipe, eol_pipe, eof_pipe;
  chan_t            med_ch [3];

  assign col_in   = {bus.prev_line_data_i, bus.cur_line_data_i, bus.next_line_data_i};
  assign last_col = img_width - COL_W'(1);
  assign last_row = img_height - ROW_W'(1);
  assign in_last  = (in_col == last_col);
  // Column 0 never launches, so a flush and a fresh line start cannot collide.
  assign launch   = flush_pend || (bus.valid_i && (in_col != '0));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_new      <= '0;
      c_mid      <= '0;
      c_old      <= '0;
      in_col     <= '0;
      flush_pend <= 1'b0;
    end else begin
      if (bus.valid_i) begin
        c_old  <= c_mid;
        c_mid  <= c_new;
        c_new  <= col_in;
        in_col <= in_last ? '0 : in_col + COL_W'(1);
      end
      flush_pend <= bus.valid_i && in_last;
    end
  end

  // The window is read from the shift register one edge after launch, so the
  // selector records where the columns will sit by then.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_sel  <= WIN_NORM;
      out_col  <= '0;
      out_row  <= '0;
      v_pipe   <= '0;
      eol_pipe <= '0;
      eof_pipe <= '0;
    end else begin
      v_pipe   <= {v_pipe[2:0], launch};
      eol_pipe <= {eol_pipe[2:0], launch && (out_col == last_col)};
      eof_pipe <= {eof_pipe[2:0], launch && (out_col == last_col) && (out_row == last_row)};
      if (launch) begin
        if (flush_pend) win_sel <= bus.valid_i ? WIN_FLUSH_SH : WIN_FLUSH_HOLD;
        else            win_sel <= (in_col == COL_W'(1)) ? WIN_LREP : WIN_NORM;
        if (out_col == last_col) begin
          out_col <= '0;
          out_row <= (out_row == last_row) ? '0 : out_row + ROW_W'(1);
        end else begin
          out_col <= out_col + COL_W'(1);
        end
      end
    end
  end

  always_comb begin
    win_l = c_old;
    win_c = c_mid;
    win_r = c_new;
    case (win_sel)
      WIN_LREP:     win_l = c_mid;
      WIN_FLUSH_SH: win_r = c_mid;
      WIN_FLUSH_HOLD: begin
        win_l = c_mid;
        win_c = c_new;
      end
      default: ;
    endcase
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    median9_ch u_med (
      .clk   (clk),
      .rst_n (reset_n),
      .col_l ({win_l.next[ch*CH_W +: CH_W], win_l.cur[ch*CH_W +: CH_W], win_l.prev[ch*CH_W +: CH_W]}),
      .col_c ({win_c.next[ch*CH_W +: CH_W], win_c.cur[ch*CH_W +: CH_W], win_c.prev[ch*CH_W +: CH_W]}),
      .col_r ({win_r.next[ch*CH_W +: CH_W], win_r.cur[ch*CH_W +: CH_W], win_r.prev[ch*CH_W +: CH_W]}),
      .med   (med_ch[ch])
    );
  end

  assign bus.valid_o = v_pipe[3];
  assign bus.data_o  = {med_ch[2], med_ch[1], med_ch[0]};
  assign bus.eol_o   = eol_pipe[3];
  assign bus.eof_o   = eof_pipe[3];
endmodule

// File: tb/tb_median3x3_filter.sv
// Bench for median3x3_filter: directed frames plus random frames checked
// against a sort-based 3x3 median model with cycle-exact output timing.
`timescale 1ns/1ps
module tb_median3x3_filter;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] img_width = 11'd4;
  logic [9:0]  img_height = 10'd3;

  median3x3_filter_if #(.DATA_W(24)) bus();

  median3x3_filter #(.DATA_W(24), .COL_W(11), .ROW_W(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .img_width  (img_width),
    .img_height (img_height),
    .bus        (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail = 0;
  logic [25:0] exp_q[$];      // {eol, eof, data}
  int          exp_cyc_q[$];  // cycle the output must be visible in
  logic [25:0] mon_e;

  logic [23:0] f_prev [6][16];
  logic [23:0] f_cur  [6][16];
  logic [23:0] f_next [6][16];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: gather the 9 clamped neighbours per channel, sort, take the 5th.
  function automatic logic [23:0] ref_median(input int r, input int c, input int w);
    logic [23:0] res;
    int          q[$];
    int          cc;
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      q.delete();
      for (int dc = -1; dc <= 1; dc++) begin
        cc = c + dc;
        if (cc < 0) cc = 0;
        if (cc > w - 1) cc = w - 1;
        q.push_back(int'(f_prev[r][cc][ch*8 +: 8]));
        q.push_back(int'(f_cur[r][cc][ch*8 +: 8]));
        q.push_back(int'(f_next[r][cc][ch*8 +: 8]));
      end
      q.sort();
      res[ch*8 +: 8] = 8'(q[4]);
    end
    return res;
  endfunction

  task automatic push_exp(input int r, input int c, input int w, input int h, input int t);
    logic eol, eof;
    eol = (c == w - 1);
    eof = eol && (r == h - 1);
    exp_q.push_back({eol, eof, ref_median(r, c, w)});
    exp_cyc_q.push_back(t);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
        mon_e = exp_q.pop_front();
        void'(exp_cyc_q.pop_front());
        check("valid_o", 32'(bus.valid_o), 32'd1);
        check("data_o", 32'(bus.data_o), 32'(mon_e[23:0]));
        check("eol_o", 32'(bus.eol_o), 32'(mon_e[25]));
        check("eof_o", 32'(bus.eof_o), 32'(mon_e[24]));
      end else begin
        check("idle_valid_o", 32'(bus.valid_o), 32'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.valid_i          = 1'b0;
    bus.prev_line_data_i = 24'($urandom);
    bus.cur_line_data_i  = 24'($urandom);
    bus.next_line_data_i = 24'($urandom);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_col(input int r, input int c, input int w, input int h);
    int samp;
    bus.valid_i          = 1'b1;
    bus.prev_line_data_i = f_prev[r][c];
    bus.cur_line_data_i  = f_cur[r][c];
    bus.next_line_data_i = f_next[r][c];
    samp = cyc + 1;
    if (c >= 1) push_exp(r, c - 1, w, h, samp + 3);
    if (c == w - 1) push_exp(r, w - 1, w, h, samp + 4);
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic run_frame(input int w, input int h, input int gap_max);
    img_width  = 11'(w);
    img_height = 10'(h);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++) begin
        repeat ($urandom_range(0, gap_max)) idle();
        drive_col(r, c, w, h);
      end
    repeat (8) idle();
  endtask

  task automatic fill_const(input logic [23:0] v);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 16; c++) begin
        f_prev[r][c] = v;
        f_cur[r][c]  = v;
        f_next[r][c] = v;
      end
  endtask

  task automatic fill_random();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 16; c++) begin
        f_prev[r][c] = 24'($urandom);
        f_cur[r][c]  = 24'($urandom);
        f_next[r][c] = 24'($urandom);
      end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid_o"}, 32'(bus.valid_o), 32'd0);
    check({tag, "_data_o"}, 32'(bus.data_o), 32'd0);
    check({tag, "_eol_o"}, 32'(bus.eol_o), 32'd0);
    check({tag, "_eof_o"}, 32'(bus.eof_o), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.valid_i          = 1'b0;
    bus.prev_line_data_i = '0;
    bus.cur_line_data_i  = '0;
    bus.next_line_data_i = '0;
    #2;
    check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) idle();

    // Uniform 4x3 frame
    fill_const(24'h102030);
    run_frame(4, 3, 0);

    // Impulse rejection on the centre line
    fill_const(24'h000000);
    for (int r = 0; r < 3; r++) f_cur[r][2] = 24'hFFFFFF;
    run_frame(5, 3, 0);

    // Channel independence: R and G windows around column 1 hold 1..9
    fill_random();
    f_prev[0][0] = 24'h020200; f_cur[0][0] = 24'h030800; f_next[0][0] = 24'h040300;
    f_prev[0][1] = 24'h090100; f_cur[0][1] = 24'h010500; f_next[0][1] = 24'h050900;
    f_prev[0][2] = 24'h060700; f_cur[0][2] = 24'h070400; f_next[0][2] = 24'h080600;
    run_frame(3, 1, 0);

    // Minimum width with both edges replicated
    fill_const(24'h000000);
    f_prev[0][0] = 24'h00000A; f_cur[0][0] = 24'h00000A; f_next[0][0] = 24'h00000A;
    f_prev[0][1] = 24'h000014; f_cur[0][1] = 24'h000014; f_next[0][1] = 24'h000014;
    run_frame(2, 1, 0);

    // Back-to-back 3-wide lines, no blanking
    fill_random();
    run_frame(3, 5, 0);

    // Random frames with random gaps
    for (int i = 0; i < 6; i++) begin
      fill_random();
      run_frame($urandom_range(2, 12), $urandom_range(1, 5), $urandom_range(0, 2));
    end

    // Async reset after column 2 of an 8-wide line
    fill_random();
    img_width  = 11'd8;
    img_height = 10'd2;
    for (int c = 0; c < 3; c++) drive_col(0, c, 8, 2);
    reset_n = 1'b0;
    exp_q.delete();
    exp_cyc_q.delete();
    #1;
    check_reset_outputs("midline_reset");
    repeat (2) idle();
    reset_n = 1'b1;
    repeat (6) idle();
    fill_random();
    run_frame(8, 2, 1);

    check("drain_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
